// File: rtl/seq_shift_pkg.sv
// rtl/seq_shift_pkg.sv - mode encodings, FSM states and effective shift amount for seq_shifter
package seq_shift_pkg;

  localparam logic [2:0] MODE_SHR  = 3'd0;
  localparam logic [2:0] MODE_SHRA = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Widest operand the amount helper accepts; narrower B is zero-extended.
  localparam int AMT_MAX_W = 128;

  function automatic int unsigned shift_amount(input logic [2:0] mode,
                                               input logic [AMT_MAX_W-1:0] b,
                                               input int unsigned width);
    logic [AMT_MAX_W-1:0] w;
    w = AMT_MAX_W'(width);
    case (mode)
      MODE_SHR, MODE_SHRA, MODE_SHL: shift_amount = (b >= w) ? width : 32'(b);
      MODE_ROR, MODE_ROL:            shift_amount = 32'(b % w);
      default:                       shift_amount = 0;
    endcase
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// rtl/seq_shifter_if.sv - start/done request bus between control unit and seq_shifter
interface seq_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;

  modport master (output start, mode, A, B, input busy, done, Result);
  modport slave  (input start, mode, A, B, output busy, done, Result);
endinterface

// File: rtl/seq_shifter_shift_step.sv
// rtl/seq_shifter_shift_step.sv - combinational shift of value by k (1..STEP) places in a given mode
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       mode,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] shifted
);

  // Complementary distance for rotates; k==WIDTH gives 0, i.e. value unchanged.
  logic [31:0] rk;
  assign rk = 32'(WIDTH) - 32'(k);

  always_comb begin
    shifted = value;
    case (mode)
      MODE_SHR:  shifted = value >> k;
      MODE_SHRA: shifted = $signed(value) >>> k;
      MODE_SHL:  shifted = value << k;
      MODE_ROR:  shifted = (value >> k) | (value << rk);
      MODE_ROL:  shifted = (value << k) | (value >> rk);
      default:   shifted = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter, up to STEP bits per clock under start/done handshake
module seq_shifter
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clock,
  input logic         clear,
  seq_shifter_if.slave bus
);

  localparam int KW = $clog2(STEP + 1);

  state_e           state;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] k_cnt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] stepped;
  logic             busy_q;
  logic             done_q;

  assign n     = CNT_W'(shift_amount(bus.mode, AMT_MAX_W'(bus.B), WIDTH));
  assign k_cnt = (count > CNT_W'(STEP)) ? CNT_W'(STEP) : count;
  assign k     = KW'(k_cnt);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (result_q),
    .mode    (mode_q),
    .k       (k),
    .shifted (stepped)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      mode_q   <= MODE_SHR;
      count    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            result_q <= bus.A;
            mode_q   <= bus.mode;
            count    <= n;
            busy_q   <= 1'b1;
            if (n == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          result_q <= stepped;
          count    <= count - k_cnt;
          if (count == k_cnt) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not sampled here; a new request waits for IDLE.
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = result_q;

endmodule
